// File: rtl/mio_bus_ctrl.sv
// Sequenced MMIO bus controller: req/ready handshake, registered read data,
// I/O wait states and button events (sticky read-to-clear with MIO_BTN_LATCH_EN).
module mio_bus_ctrl #(
    parameter int RAM_AW   = 12,
    parameter int BTN_W    = 6,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Cpu_data2bus,
    output logic [31:0]       Cpu_data4bus,
    output logic              bus_ready,
    output logic              bus_err,
    input  logic [31:0]       ram_data_out,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data_in,
    output logic              data_ram_we,
    output logic              GPIOe0000000_we,
    output logic              GPIOf0000000_we,
    output logic              counter_we,
    output logic [31:0]       Peripheral_in,
    input  logic [31:0]       counter_out,
    input  logic              counter0_out,
    input  logic              counter1_out,
    input  logic              counter2_out,
    input  logic [15:0]       led_out,
    input  logic [3:0]        BTN,
    input  logic [15:0]       SW,
    input  logic [BTN_W-1:0]  btn_in,
    output logic [31:0]       score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] score_q;
    logic        accept;

    logic [BTN_W-1:0] sync1_q, sync2_q;
    logic [31:0]      btn_word;

    logic sel_ram, sel_score, sel_btn, sel_e;
    logic sel_f0, sel_f1, sel_f2, unmapped;
    logic [31:0] rd_mux;
    logic wr_go, cap;

    always_comb begin
        sel_ram   = 1'b0;
        sel_score = 1'b0;
        sel_btn   = 1'b0;
        sel_e     = 1'b0;
        sel_f0    = 1'b0;
        sel_f1    = 1'b0;
        sel_f2    = 1'b0;
        unmapped  = 1'b0;
        unique case (addr_q[31:28])
            4'h0: sel_ram   = 1'b1;
            4'hC: sel_score = 1'b1;
            4'hD: sel_btn   = 1'b1;
            4'hE: sel_e     = 1'b1;
            4'hF: begin
                unique case (addr_q[3:2])
                    2'b00:   sel_f0   = 1'b1;
                    2'b01:   sel_f1   = 1'b1;
                    2'b10:   sel_f2   = 1'b1;
                    default: unmapped = 1'b1;
                endcase
            end
            default: unmapped = 1'b1;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        if (sel_ram)
            rd_mux = ram_data_out;
        else if (sel_score)
            rd_mux = score_q;
        else if (sel_btn)
            rd_mux = btn_word;
        else if (sel_e || sel_f1)
            rd_mux = counter_out;
        else if (sel_f0)
            rd_mux = {counter0_out, counter1_out, counter2_out,
                      9'h0, BTN, SW};
        else if (sel_f2)
            rd_mux = {16'h0, led_out};
    end

    // Strobes fire once, in the first XFER cycle, regardless of wait states.
    assign wr_go = (state_q == XFER) && first_q && we_q;
    assign cap   = (state_q == XFER) && (cnt_q == 4'd0);

    assign data_ram_we     = wr_go & sel_ram;
    assign GPIOe0000000_we = wr_go & sel_e;
    assign GPIOf0000000_we = wr_go & sel_f0;
    assign counter_we      = wr_go & sel_f1;

    assign ram_addr      = addr_q[RAM_AW+1:2];
    assign ram_data_in   = wdata_q;
    assign Peripheral_in = wdata_q;
    assign Cpu_data4bus  = rdata_q;
    assign score         = score_q;
    assign bus_ready     = (state_q == RESP);
    assign bus_err       = bus_ready & err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                if (cpu_req) begin
                    accept  = 1'b1;
                    state_d = XFER;
                    cnt_d   = (addr_bus[31:28] == 4'h0) ?
                              4'd0 : 4'(WAIT_CYC);
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (cnt_q == 4'd0)
                    state_d = RESP;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            score_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= accept;
            if (accept) begin
                addr_q  <= addr_bus;
                wdata_q <= Cpu_data2bus;
                we_q    <= mem_w;
            end
            if (cap) begin
                rdata_q <= rd_mux;
                err_q   <= unmapped;
            end
            if (wr_go && sel_score && (addr_q[27:0] == 28'h0))
                score_q <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef MIO_BTN_LATCH_EN
    logic [BTN_W-1:0] prev_q;
    logic [BTN_W-1:0] evt_q, evt_d;
    logic [BTN_W-1:0] clr;
    logic [BTN_W-1:0] rise;

    assign rise = sync2_q & ~prev_q;
    assign clr  = (cap && sel_btn && !we_q) ? evt_q : '0;

    // A rise in the capture cycle survives the clear.
    always_comb begin
        evt_d = (evt_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            evt_q  <= '0;
        end else begin
            prev_q <= sync2_q;
            evt_q  <= evt_d;
        end
    end

    always_comb begin
        btn_word = 32'h0;
        btn_word[BTN_W-1:0] = evt_q;
    end
`else
    always_comb begin
        btn_word = 32'h0;
        btn_word[BTN_W-1:0] = sync2_q;
    end
`endif

endmodule
